// File: rtl/msg_out_arbiter.sv
// rtl/msg_out_arbiter.sv - four-source round-robin arbiter onto one four-phase message channel
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 16
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

module msg_out_arbiter #(
    parameter int ASZ = `NS_ADDRESS_SIZE,
    parameter int DSZ = `NS_DATA_SIZE,
    parameter int RSZ = `NS_REDUN_SIZE
) (
    input  logic           src_clk,
    input  logic           src_rst_n,
    input  logic           i0_req,
    output logic           i0_ack,
    input  logic [ASZ-1:0] i0_src,
    input  logic [ASZ-1:0] i0_dst,
    input  logic [DSZ-1:0] i0_dat,
    input  logic [RSZ-1:0] i0_red,
    input  logic           i1_req,
    output logic           i1_ack,
    input  logic [ASZ-1:0] i1_src,
    input  logic [ASZ-1:0] i1_dst,
    input  logic [DSZ-1:0] i1_dat,
    input  logic [RSZ-1:0] i1_red,
    input  logic           i2_req,
    output logic           i2_ack,
    input  logic [ASZ-1:0] i2_src,
    input  logic [ASZ-1:0] i2_dst,
    input  logic [DSZ-1:0] i2_dat,
    input  logic [RSZ-1:0] i2_red,
    input  logic           i3_req,
    output logic           i3_ack,
    input  logic [ASZ-1:0] i3_src,
    input  logic [ASZ-1:0] i3_dst,
    input  logic [DSZ-1:0] i3_dat,
    input  logic [RSZ-1:0] i3_red,
    output logic           o0_req,
    input  logic           o0_ack,
    output logic [ASZ-1:0] o0_src,
    output logic [ASZ-1:0] o0_dst,
    output logic [DSZ-1:0] o0_dat,
    output logic [RSZ-1:0] o0_red,
    output logic           busy,
    output logic [1:0]     gnt_idx,
    output logic [15:0]    fwd_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_RELEASE} state_t;

    state_t         r_state;
    logic [1:0]     r_ptr;
    logic [1:0]     r_gnt;
    logic [15:0]    r_fwd_cnt;
    logic           r_req;
    logic [3:0]     r_ack;
    logic [ASZ-1:0] r_src;
    logic [ASZ-1:0] r_dst;
    logic [DSZ-1:0] r_dat;
    logic [RSZ-1:0] r_red;

    logic [3:0]     w_req;
    logic [ASZ-1:0] w_src [4];
    logic [ASZ-1:0] w_dst [4];
    logic [DSZ-1:0] w_dat [4];
    logic [RSZ-1:0] w_red [4];
    logic           w_found;
    logic [1:0]     w_win;
    logic [1:0]     w_idx;

    assign w_req    = {i3_req, i2_req, i1_req, i0_req};
    assign w_src[0] = i0_src;
    assign w_src[1] = i1_src;
    assign w_src[2] = i2_src;
    assign w_src[3] = i3_src;
    assign w_dst[0] = i0_dst;
    assign w_dst[1] = i1_dst;
    assign w_dst[2] = i2_dst;
    assign w_dst[3] = i3_dst;
    assign w_dat[0] = i0_dat;
    assign w_dat[1] = i1_dat;
    assign w_dat[2] = i2_dat;
    assign w_dat[3] = i3_dat;
    assign w_red[0] = i0_red;
    assign w_red[1] = i1_red;
    assign w_red[2] = i2_red;
    assign w_red[3] = i3_red;

    // Winner search: walk offsets from farthest to nearest so the source closest to ptr wins last.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        w_idx   = r_ptr;
        for (int j = 3; j >= 0; j--) begin
            w_idx = r_ptr + 2'(j);
            if (w_req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // Arbitration and four-phase handshake state machine with registered outputs.
    always_ff @(posedge src_clk) begin
        if (!src_rst_n) begin
            r_state   <= S_IDLE;
            r_ptr     <= 2'd0;
            r_gnt     <= 2'd0;
            r_fwd_cnt <= 16'd0;
            r_req     <= 1'b0;
            r_ack     <= 4'd0;
            r_src     <= '0;
            r_dst     <= '0;
            r_dat     <= '0;
            r_red     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_src   <= w_src[w_win];
                        r_dst   <= w_dst[w_win];
                        r_dat   <= w_dat[w_win];
                        r_red   <= w_red[w_win];
                        r_gnt   <= w_win;
                        r_req   <= 1'b1;
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (o0_ack) begin
                        r_req        <= 1'b0;
                        r_ack[r_gnt] <= 1'b1;
                        r_state      <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    // Source req and sink ack must both be low before the channel is free again.
                    if (!w_req[r_gnt] && !o0_ack) begin
                        r_ack     <= 4'd0;
                        r_fwd_cnt <= r_fwd_cnt + 16'd1;
                        r_ptr     <= r_gnt + 2'd1;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign i0_ack  = r_ack[0];
    assign i1_ack  = r_ack[1];
    assign i2_ack  = r_ack[2];
    assign i3_ack  = r_ack[3];
    assign o0_req  = r_req;
    assign o0_src  = r_src;
    assign o0_dst  = r_dst;
    assign o0_dat  = r_dat;
    assign o0_red  = r_red;
    assign busy    = (r_state != S_IDLE);
    assign gnt_idx = r_gnt;
    assign fwd_cnt = r_fwd_cnt;

endmodule
